// File: rtl/des_core_arbiter.sv
// Round-robin arbiter sharing one DES core between NREQ job ports.
// Optional RUN-phase timeout abort enabled by defining DES_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module des_core_arbiter #(
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_data,
    input  logic [64*NREQ-1:0]   req_key,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 core_start,
    output logic [63:0]          core_din,
    output logic [63:0]          core_key,
    input  logic                 core_ready,
    input  logic [63:0]          core_dout
);

    typedef enum logic [1:0] {IDLE, RUN, RELEASE, RESP} state_t;

    localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;
    localparam int GW      = $clog2(GAP_EFF + 1);

    state_t         state, state_next;
    logic [IDW-1:0] ptr, job_id, grant_id, hi_id, lo_id;
    logic           grant_any, hi_any, lo_any;
    logic [63:0]    job_din, job_key;
    logic [GW-1:0]  gap_cnt;
    logic           run_done, run_abort;

`ifdef DES_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]  run_cnt;
    logic           err_q;
`endif

    // First valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_any = 1'b0;
        hi_id  = '0;
        lo_any = 1'b0;
        lo_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                lo_any = 1'b1;
                lo_id  = IDW'(k);
                if (k >= int'(ptr)) begin
                    hi_any = 1'b1;
                    hi_id  = IDW'(k);
                end
            end
        end
        grant_any = lo_any;
        grant_id  = hi_any ? hi_id : lo_id;
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_any && rst_n)
            req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        state_next = state;
        run_done   = 1'b0;
        run_abort  = 1'b0;
        case (state)
            IDLE:    if (grant_any) state_next = RUN;
            RUN: begin
                if (core_ready) begin
                    run_done   = 1'b1;
                    state_next = RELEASE;
                end
`ifdef DES_ARB_TIMEOUT_EN
                else if (run_cnt == TW'(TIMEOUT - 1)) begin
                    run_abort  = 1'b1;
                    state_next = RELEASE;
                end
`endif
            end
            RELEASE: if (gap_cnt == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // core_start is registered off the next state so it rises with the first RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            job_id     <= '0;
            job_din    <= '0;
            job_key    <= '0;
            rsp_data   <= '0;
            gap_cnt    <= '0;
            core_start <= 1'b0;
        end else begin
            state      <= state_next;
            core_start <= (state_next == RUN);
            if (state == IDLE && grant_any) begin
                job_id  <= grant_id;
                job_din <= req_data[64*grant_id +: 64];
                job_key <= req_key[64*grant_id +: 64];
            end
            if (run_done)
                rsp_data <= core_dout;
            else if (run_abort)
                rsp_data <= '0;
            if (state == RUN && state_next == RELEASE)
                gap_cnt <= GW'(GAP_EFF - 1);
            else if (state == RELEASE && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (state == RESP && rsp_ready)
                ptr <= (job_id == IDW'(NREQ - 1)) ? '0 : job_id + 1'b1;
        end
    end

`ifdef DES_ARB_TIMEOUT_EN
    // Counter sits at zero outside RUN, so it is implicitly cleared on every RUN entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state != RUN)
                run_cnt <= '0;
            else
                run_cnt <= run_cnt + 1'b1;
            if (run_done)
                err_q <= 1'b0;
            else if (run_abort)
                err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign rsp_err        = 1'b0;
`endif

    assign rsp_valid = (state == RESP);
    assign rsp_id    = job_id;
    assign busy      = (state != IDLE);
    assign core_din  = job_din;
    assign core_key  = job_key;

endmodule

// File: tb/tb_des_core_arbiter.sv
// Scoreboard bench for des_core_arbiter with a behavioural DES core stand-in.
// Grants and responses are predicted from round-robin rules over randomized traffic.
`timescale 1ns/1ps

module tb_des_core_arbiter;

    localparam int NREQ    = 2;
    localparam int IDW     = 1;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [64*NREQ-1:0]  req_data;
    logic [64*NREQ-1:0]  req_key;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [63:0]         rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_err;
    logic                busy;
    logic                core_start;
    logic [63:0]         core_din;
    logic [63:0]         core_key;
    logic                core_ready;
    logic [63:0]         core_dout;

    des_core_arbiter #(.NREQ(NREQ), .IDW(IDW), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy), .core_start(core_start),
        .core_din(core_din), .core_key(core_key),
        .core_ready(core_ready), .core_dout(core_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [63:0]    data;
        logic           err;
    } exp_t;

    exp_t            exp_q[$];
    logic [IDW-1:0]  seen_ids[$];
    int              checks = 0;
    int              failures = 0;
    int              model_ptr = 0;
    bit              model_idle = 1'b1;
    int              core_mode = 0;
    bit              spurious_en = 1'b0;
    int              rsp_count = 0;
    int              low_cnt = 0;
    bit              prev_rsp_valid = 1'b0;
    bit              prev_stall = 1'b0;
    logic [63:0]     prev_data;
    logic [IDW-1:0]  prev_id;
    logic [63:0]     last_rsp_data;
    logic [NREQ-1:0] exp_onehot;
    exp_t            e;
    int              g;

    // Stand-in cipher: the published DES vector is honoured exactly, anything else is a keyed mix.
    function automatic logic [63:0] des_model(input logic [63:0] d, input logic [63:0] k);
        if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1)
            return 64'h85E813540F0AB405;
        return {d[31:0] ^ k[63:32], d[63:32] + k[31:0]} ^ 64'hA5A50F0F3C3C9696;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic r, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            req_valid = v;
            rsp_ready = r;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic randomizeData();
        for (int k = 0; k < NREQ; k++) begin
            req_data[64*k +: 64] = {$urandom, $urandom};
            req_key[64*k +: 64]  = {$urandom, $urandom};
        end
    endtask

    // Core stand-in: answers after a random latency while start is held; may pulse ready spuriously when idle.
    initial begin
        int ccnt;
        int lat;
        core_ready = 1'b0;
        core_dout  = '0;
        ccnt = 0;
        lat  = 1;
        forever begin
            @(posedge clk);
            #1;
            if (!core_start) begin
                ccnt       = 0;
                lat        = (core_mode == 1) ? 30 : $urandom_range(1, 6);
                core_ready = spurious_en && ($urandom_range(0, 7) == 0);
                core_dout  = {$urandom, $urandom};
            end else if (core_mode != 2 && ccnt >= lat) begin
                core_ready = 1'b1;
                core_dout  = des_model(core_din, core_key);
            end else begin
                core_ready = 1'b0;
                ccnt++;
            end
        end
    end

    // Monitor: predicts each grant from the model pointer and checks every response against the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_ptr      = 0;
            model_idle     = 1'b1;
            low_cnt        = 0;
            prev_rsp_valid = 1'b0;
            prev_stall     = 1'b0;
        end else begin
            exp_onehot = '0;
            if (model_idle && req_valid != '0) begin
                g = -1;
                for (int i = 0; i < NREQ; i++) begin
                    int k;
                    k = (model_ptr + i) % NREQ;
                    if (g < 0 && req_valid[k]) g = k;
                end
                exp_onehot[g] = 1'b1;
                e.id   = IDW'(g);
                e.err  = (core_mode == 2);
                e.data = (core_mode == 2) ? 64'h0 : des_model(req_data[64*g +: 64], req_key[64*g +: 64]);
                exp_q.push_back(e);
                model_idle = 1'b0;
            end
            checkOutput("req_ready", 64'(req_ready), 64'(exp_onehot));
            if (busy && !core_start && !rsp_valid)
                low_cnt++;
            if (rsp_valid) begin
                checkOutput("busy_in_resp", 64'(busy), 64'd1);
                if (!prev_rsp_valid) begin
                    checkOutput("gap_cycles", 64'(low_cnt), 64'(GAP));
                    low_cnt = 0;
                end
                if (prev_stall) begin
                    checkOutput("stall_data", rsp_data, prev_data);
                    checkOutput("stall_id", 64'(rsp_id), 64'(prev_id));
                end
                prev_data  = rsp_data;
                prev_id    = rsp_id;
                prev_stall = !rsp_ready;
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_rsp: got response id %0d, required no response", rsp_id);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
                        checkOutput("rsp_data", rsp_data, e.data);
                        checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
                        seen_ids.push_back(rsp_id);
                        last_rsp_data = rsp_data;
                        rsp_count++;
                        model_ptr  = (int'(e.id) + 1) % NREQ;
                        model_idle = 1'b1;
                    end
                end
            end else begin
                prev_stall = 1'b0;
            end
            prev_rsp_valid = rsp_valid;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_data  = '0;
        req_key   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", rsp_data, 64'd0);
        checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_core_start", 64'(core_start), 64'd0);
        checkOutput("rst_core_din", core_din, 64'd0);
        checkOutput("rst_core_key", core_key, 64'd0);
        rst_n = 1'b1;

        // Single job with the reference DES vector on requester 0.
        req_data[63:0] = 64'h0123456789ABCDEF;
        req_key[63:0]  = 64'h133457799BBCDFF1;
        base = rsp_count;
        applyStimulus(2'b01, 1'b1, 1);
        applyStimulus(2'b00, 1'b1, 30);
        checkOutput("single_count", 64'(rsp_count - base), 64'd1);
        checkOutput("single_data", last_rsp_data, 64'h85E813540F0AB405);
        checkOutput("single_id", 64'(seen_ids[$]), 64'd0);

        // Contention: both requesters valid from reset.
        randomizeData();
        req_valid = 2'b11;
        doReset();
        seen_ids.delete();
        applyStimulus(2'b11, 1'b1, 60);
        checkOutput("cont_id0", (seen_ids.size() > 0) ? 64'(seen_ids[0]) : 64'hx, 64'd0);
        checkOutput("cont_id1", (seen_ids.size() > 1) ? 64'(seen_ids[1]) : 64'hx, 64'd1);
        checkOutput("cont_id2", (seen_ids.size() > 2) ? 64'(seen_ids[2]) : 64'hx, 64'd0);
        checkOutput("cont_id3", (seen_ids.size() > 3) ? 64'(seen_ids[3]) : 64'hx, 64'd1);
        applyStimulus(2'b00, 1'b1, 20);

        // Backpressure: stall in RESP with both requesters pending.
        doReset();
        seen_ids.delete();
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("bp_reached_resp", 64'(rsp_valid), 64'd1);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_busy", 64'(busy), 64'd1);
        end
        applyStimulus(2'b11, 1'b1, 20);
        checkOutput("bp_first_id", (seen_ids.size() > 0) ? 64'(seen_ids[0]) : 64'hx, 64'd0);
        checkOutput("bp_second_id", (seen_ids.size() > 1) ? 64'(seen_ids[1]) : 64'hx, 64'd1);
        applyStimulus(2'b00, 1'b1, 20);

        // Reset five cycles after a grant while the core is still running.
        doReset();
        core_mode = 1;
        applyStimulus(2'b01, 1'b1, 1);
        applyStimulus(2'b00, 1'b1, 4);
        checkOutput("mid_run_start", 64'(core_start), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_core_start", 64'(core_start), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        core_mode = 0;
        seen_ids.delete();
        applyStimulus(2'b11, 1'b1, 20);
        checkOutput("post_rst_first_id", (seen_ids.size() > 0) ? 64'(seen_ids[0]) : 64'hx, 64'd0);
        applyStimulus(2'b00, 1'b1, 20);

        // Core that never answers.
        doReset();
        core_mode = 2;
        base = rsp_count;
        applyStimulus(2'b01, 1'b1, 1);
`ifdef DES_ARB_TIMEOUT_EN
        applyStimulus(2'b00, 1'b1, 30);
        checkOutput("timeout_rsp_count", 64'(rsp_count - base), 64'd1);
        checkOutput("timeout_core_start", 64'(core_start), 64'd0);
        checkOutput("timeout_busy", 64'(busy), 64'd0);
`else
        for (int c = 0; c < 200; c++) begin
            applyStimulus(2'b00, 1'b1, 1);
            checkOutput("hang_busy", 64'(busy), 64'd1);
            checkOutput("hang_core_start", 64'(core_start), 64'd1);
        end
        checkOutput("hang_rsp_count", 64'(rsp_count - base), 64'd0);
`endif
        core_mode = 0;

        // Randomized traffic with spurious core_ready pulses outside RUN.
        doReset();
        spurious_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) randomizeData();
            applyStimulus(NREQ'($urandom), ($urandom_range(0, 3) != 0), 1);
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
